// File: rtl/maze_pkg.sv
// Shared types for the maze front end: move directions, encoder FSM states
// and the KEY[3:0] bit positions.
package maze_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_HOLD
   } state_t;

   localparam int unsigned KEY_LEFT  = 3;
   localparam int unsigned KEY_RIGHT = 2;
   localparam int unsigned KEY_UP    = 1;
   localparam int unsigned KEY_DOWN  = 0;

   // LEFT > RIGHT > UP > DOWN when several presses land in the same cycle.
   function automatic dir_t pick_dir(input logic [3:0] evt);
      if (evt[KEY_LEFT])       return DIR_LEFT;
      else if (evt[KEY_RIGHT]) return DIR_RIGHT;
      else if (evt[KEY_UP])    return DIR_UP;
      else                     return DIR_DOWN;
   endfunction

   // Key bit position that produced a given direction.
   function automatic logic [1:0] key_of(input dir_t d);
      return 2'(KEY_LEFT) - d;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button conditioner: 2-FF synchroniser on the inverted raw key,
// stability counter, debounced level and a one-cycle press pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic stable,
   output logic press_evt
);

   localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= ~key_n;
         sync2 <= sync1;
      end
   end

   // Any sample agreeing with the accepted level restarts the stability run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         stable    <= 1'b0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            stable    <= sync2;
            press_evt <= sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/key_move_encoder.sv
// Maze key front end: four debounced buttons -> one valid/ready move request per press.
// Define KEY_MOVE_AUTO_REPEAT_EN to re-issue a held key's move after REPEAT_DELAY, then every REPEAT_RATE.
module key_move_encoder
   import maze_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned REPEAT_DELAY    = 25_000_000,
   parameter int unsigned REPEAT_RATE     = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_n,
   output logic       move_valid,
   output logic [1:0] move_dir,
   input  logic       move_ready,
   output logic       any_held
);

   if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_cfg_check
      $error("key_move_encoder: REPEAT_DELAY and REPEAT_RATE must be at least 2");
   end

   logic [3:0] stable;
   logic [3:0] press_evt;
   state_t     state, state_nxt;
   dir_t       dir_q;
   logic       released;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .key_n    (key_n[k]),
         .stable   (stable[k]),
         .press_evt(press_evt[k])
      );
   end

   assign released = ~stable[key_of(dir_q)];
   assign any_held = |stable;
   assign move_dir = dir_q;

`ifdef KEY_MOVE_AUTO_REPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW      = $clog2(RPT_MAX + 1);

   logic [RW-1:0] rpt_cnt;
   logic          first_q;

   // Loaded two short: HOLD spans load+1 cycles and the ISSUE cycle completes
   // the interval, so accepts are exactly REPEAT_DELAY / REPEAT_RATE apart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rpt_cnt <= '0;
         first_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:  if (|press_evt) first_q <= 1'b1;
            ST_ISSUE: if (move_ready) begin
                         rpt_cnt <= first_q ? RW'(REPEAT_DELAY - 2) : RW'(REPEAT_RATE - 2);
                         first_q <= 1'b0;
                      end
            ST_HOLD:  if (!released && rpt_cnt != '0) rpt_cnt <= rpt_cnt - RW'(1);
            default:  ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (|press_evt) state_nxt = ST_ISSUE;
         ST_ISSUE: if (move_ready) state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (released) state_nxt = ST_IDLE;
`ifdef KEY_MOVE_AUTO_REPEAT_EN
            else if (rpt_cnt == '0) state_nxt = ST_ISSUE;
`endif
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      move_valid = (state == ST_ISSUE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                             dir_q <= DIR_LEFT;
      else if (state == ST_IDLE && |press_evt) dir_q <= pick_dir(press_evt);
   end

endmodule
